// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the two-port stack arbiter.
package stack_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin picker; on contention the port not granted last time wins.
module stack_arbiter_rr
  import stack_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_sel   = PORT_A;
    if (req_a && req_b) begin
      grant_sel = ~last_grant;
    end else if (req_b) begin
      grant_sel = PORT_B;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Serialises push/pop requests from ports A and B onto one stack instance.
// Optional error counter output enabled by STACK_ARBITER_ERRCNT_EN.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_value_in,
  input  logic [DATA_W-1:0] stk_value_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
`ifdef STACK_ARBITER_ERRCNT_EN
  output logic [7:0]        err_count,
  output logic              empty
`else
  output logic              empty
`endif
);

  state_t              state_q;
  logic                last_grant_q;
  logic                sel_q;
  logic                op_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;

  logic                grant_valid;
  logic                grant_sel;
  logic                g_op;
  logic [DATA_W-1:0]   g_wdata;
  logic                g_err;

  stack_arbiter_rr u_rr (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    g_op    = (grant_sel == PORT_A) ? a_op : b_op;
    g_wdata = (grant_sel == PORT_A) ? a_wdata : b_wdata;
    g_err   = (g_op == OP_PUSH) ? full : empty;
  end

  // Stack strobes and acks decode straight from state so an async reset drops them at once.
  assign stk_push     = (state_q == ISSUE) && (op_q == OP_PUSH);
  assign stk_pop      = (state_q == ISSUE) && (op_q == OP_POP);
  assign stk_value_in = stk_push ? wdata_q : '0;

  assign a_ack   = (state_q == RESP) && (sel_q == PORT_A);
  assign b_ack   = (state_q == RESP) && (sel_q == PORT_B);
  assign a_err   = a_ack & err_q;
  assign b_err   = b_ack & err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_B;
      sel_q        <= PORT_A;
      op_q         <= OP_POP;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      count_q      <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            sel_q        <= grant_sel;
            last_grant_q <= grant_sel;
            op_q         <= g_op;
            wdata_q      <= g_wdata;
            err_q        <= g_err;
            state_q      <= g_err ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          if (op_q == OP_PUSH) begin
            count_q <= count_q + CNT_W'(1);
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (op_q == OP_POP) begin
            if (sel_q == PORT_A) begin
              a_rdata_q <= stk_value_out;
            end else begin
              b_rdata_q <= stk_value_out;
            end
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef STACK_ARBITER_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if ((state_q == RESP) && err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural stack attached to its stack pins.
module tb_stack_arbiter;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              a_req, a_op, b_req, b_op;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ack, a_err, b_ack, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              stk_push, stk_pop;
  logic [DATA_W-1:0] stk_value_in, stk_value_out;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
`ifdef STACK_ARBITER_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .a_req         (a_req),
    .a_op          (a_op),
    .a_wdata       (a_wdata),
    .a_ack         (a_ack),
    .a_err         (a_err),
    .a_rdata       (a_rdata),
    .b_req         (b_req),
    .b_op          (b_op),
    .b_wdata       (b_wdata),
    .b_ack         (b_ack),
    .b_err         (b_err),
    .b_rdata       (b_rdata),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_value_in  (stk_value_in),
    .stk_value_out (stk_value_out),
    .count         (count),
    .full          (full),
`ifdef STACK_ARBITER_ERRCNT_EN
    .err_count     (err_count),
`endif
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack model: pop registers the top entry onto value_out at the popping edge.
  logic [DATA_W-1:0] mem [DEPTH];
  int                sp;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp            <= 0;
      stk_value_out <= '0;
    end else begin
      if (stk_push && sp < DEPTH) begin
        mem[sp] <= stk_value_in;
        sp      <= sp + 1;
      end
      if (stk_pop && sp > 0) begin
        stk_value_out <= mem[sp-1];
        sp            <= sp - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    a_req   = 1'b0; b_req = 1'b0;
    a_op    = 1'b0; b_op  = 1'b0;
    a_wdata = '0;   b_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic do_op(input logic port, input logic op, input logic [DATA_W-1:0] wd,
                       output int lat, output logic err, output logic [DATA_W-1:0] rdata,
                       output int n_push, output int n_pop, output logic [DATA_W-1:0] pushed,
                       output int n_other, output logic both);
    lat = 0; err = 1'b0; rdata = '0; n_push = 0; n_pop = 0; pushed = '0; n_other = 0; both = 1'b0;
    if (port == 1'b0) begin a_req = 1'b1; a_op = op; a_wdata = wd; end
    else              begin b_req = 1'b1; b_op = op; b_wdata = wd; end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (stk_push) begin n_push++; pushed = stk_value_in; end
      if (stk_pop) n_pop++;
      if (stk_push && stk_pop) both = 1'b1;
      if ((port == 1'b0 && b_ack) || (port == 1'b1 && a_ack)) n_other++;
      if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) begin
        lat   = c;
        err   = (port == 1'b0) ? a_err : b_err;
        rdata = (port == 1'b0) ? a_rdata : b_rdata;
        break;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic              port;
    logic              op;
    logic [DATA_W-1:0] wdata;
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                cnt;
    int                lat;
  } vec_t;

  vec_t vecs[16];

  int                lat, n_push, n_pop, n_other;
  logic              err, both;
  logic [DATA_W-1:0] rdata, pushed;

  initial begin
    // port: 0=A 1=B; op: 1=push 0=pop; rdata on pops is the value the port must show (held on error)
    vecs[0]  = '{1'b0, 1'b1, 16'h0013, 1'b0, 16'h0000, 1, 3};
    vecs[1]  = '{1'b1, 1'b1, 16'h00a5, 1'b0, 16'h0000, 2, 3};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h00a5, 1, 3};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0013, 0, 3};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0013, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1, 3};
    vecs[6]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 2, 3};
    vecs[7]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 3, 3};
    vecs[8]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000, 4, 3};
    vecs[9]  = '{1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 5, 3};
    vecs[10] = '{1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000, 6, 3};
    vecs[11] = '{1'b1, 1'b1, 16'h0007, 1'b0, 16'h0000, 7, 3};
    vecs[12] = '{1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000, 8, 3};
    vecs[13] = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h0000, 8, 1};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 7, 3};
    vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0007, 6, 3};

    apply_reset();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_acks", {a_ack, b_ack, a_err, b_err}, 0);
    check("rst_stk", {stk_push, stk_pop}, 0);
    check("rst_value_in", stk_value_in, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].port, vecs[i].op, vecs[i].wdata, lat, err, rdata, n_push, n_pop, pushed, n_other, both);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_err", i), err, vecs[i].err);
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_full", i), full, vecs[i].cnt == DEPTH);
      check($sformatf("v%0d_empty", i), empty, vecs[i].cnt == 0);
      check($sformatf("v%0d_npush", i), n_push, (vecs[i].op && !vecs[i].err) ? 1 : 0);
      check($sformatf("v%0d_npop", i), n_pop, (!vecs[i].op && !vecs[i].err) ? 1 : 0);
      check($sformatf("v%0d_excl", i), both, 0);
      check($sformatf("v%0d_other_ack", i), n_other, 0);
      check($sformatf("v%0d_ack_pulse", i), {a_ack, b_ack}, 0);
      if (vecs[i].op && !vecs[i].err) check($sformatf("v%0d_value_in", i), pushed, vecs[i].wdata);
      if (!vecs[i].op) check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
    end

    // Both ports push continuously: A wins first, then strict alternation every 4 cycles.
    begin
      logic              ev_port [4];
      int                ev_cyc  [4];
      logic [DATA_W-1:0] ev_val  [4];
      logic [DATA_W-1:0] exp_val [4];
      int                n_ev = 0;
      int                n_val = 0;
      exp_val[0] = 16'h0101; exp_val[1] = 16'h0201; exp_val[2] = 16'h0102; exp_val[3] = 16'h0202;
      apply_reset();
      a_req = 1'b1; a_op = 1'b1; a_wdata = 16'h0101;
      b_req = 1'b1; b_op = 1'b1; b_wdata = 16'h0201;
      for (int c = 1; c <= 40 && n_ev < 4; c++) begin
        @(posedge clk); #1;
        if (stk_push && n_val < 4) begin ev_val[n_val] = stk_value_in; n_val++; end
        if (a_ack || b_ack) begin
          ev_port[n_ev] = b_ack;
          ev_cyc[n_ev]  = c;
          n_ev++;
          if (a_ack) a_wdata = a_wdata + 16'd1;
          if (b_ack) b_wdata = b_wdata + 16'd1;
        end
      end
      a_req = 1'b0; b_req = 1'b0;
      @(posedge clk); #1;
      check("rr_events", n_ev, 4);
      check("rr_pushes", n_val, 4);
      for (int k = 0; k < n_ev; k++) begin
        check($sformatf("rr_port%0d", k), ev_port[k], k % 2);
        check($sformatf("rr_cyc%0d", k), ev_cyc[k], 3 + 4 * k);
      end
      for (int k = 0; k < n_val; k++) check($sformatf("rr_val%0d", k), ev_val[k], exp_val[k]);
      check("rr_count", count, 4);
    end

    // Reset asserted during the ISSUE cycle of a push aborts it without an ack.
    begin
      int n_ack = 0;
      apply_reset();
      a_req = 1'b1; a_op = 1'b1; a_wdata = 16'h0055;
      @(posedge clk); #1;
      check("mid_issue_push", stk_push, 1);
      reset = 1'b0;
      #1;
      check("mid_push_drop", stk_push, 0);
      check("mid_count", count, 0);
      a_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (a_ack || b_ack) n_ack++;
      end
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (a_ack || b_ack) n_ack++;
      end
      check("mid_no_ack", n_ack, 0);
      check("mid_count_after", count, 0);
      do_op(1'b0, 1'b1, 16'h0013, lat, err, rdata, n_push, n_pop, pushed, n_other, both);
      check("post_lat", lat, 3);
      check("post_err", err, 0);
      check("post_value_in", pushed, 16'h0013);
      check("post_count", count, 1);
    end

`ifdef STACK_ARBITER_ERRCNT_EN
    apply_reset();
    check("errcnt_rst", err_count, 0);
    for (int k = 0; k < 2; k++) begin
      do_op(1'b1, 1'b0, 16'h0000, lat, err, rdata, n_push, n_pop, pushed, n_other, both);
      check($sformatf("errcnt_err%0d", k), err, 1);
    end
    check("errcnt_two", err_count, 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
